// File: rtl/key_event_ctrl_pkg.sv
// Shared constants for the key event controller: event type encoding and
// the key-index width derivation used by the top level and the bench.
package key_event_ctrl_pkg;

    localparam logic EVT_PRESS   = 1'b0;
    localparam logic EVT_RELEASE = 1'b1;

    // Key index width, never narrower than one bit.
    function automatic int calc_kw(input int nkeys);
        return (nkeys <= 2) ? 1 : $clog2(nkeys);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser followed by a tick-driven debounce counter.
// flip strobes in the cycle whose rising edge will toggle st.
module key_debounce #(
    parameter int DEB_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic st,
    output logic flip
);

    logic             sync1_q, sync2_q;
    logic             st_q, st_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            st_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        flip  = 1'b0;
        if (tick) begin
            if (sync2_q == st_q) begin
                cnt_d = '0;
            end else if (&cnt_q) begin
                st_d  = ~st_q;
                cnt_d = '0;
                flip  = 1'b1;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    assign st = st_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Debounced key bank that turns accepted level changes into press/release
// events, arbitrated round-robin into a single valid/ready output register.
module key_event_ctrl
    import key_event_ctrl_pkg::*;
#(
    parameter int NKEYS   = 4,
    parameter int PRESC_W = 16,
    parameter int DEB_W   = 4,
    localparam int KW     = calc_kw(NKEYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] key_in,
    output logic [NKEYS-1:0] key_state,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [KW-1:0]    evt_key,
    output logic             evt_rel,
    output logic             ovf,
    input  logic             ovf_clr
);

    logic [PRESC_W-1:0] presc_q;
    logic               tick;
    logic [NKEYS-1:0]   st_vec, flip_vec;
    logic [NKEYS-1:0]   pend_q, pend_d, ptype_q, ptype_d, cancel;
    logic [KW-1:0]      last_q, last_d, grant_idx;
    logic               load;
    int                 rr_idx;
    logic               evt_valid_q, evt_valid_d, evt_rel_q, evt_rel_d;
    logic [KW-1:0]      evt_key_q, evt_key_d;
    logic               ovf_q, ovf_d;

    assign tick = &presc_q;

    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
            key_debounce #(.DEB_W(DEB_W)) u_deb (
                .clk  (clk),
                .rst_n(rst_n),
                .tick (tick),
                .raw  (key_in[gi]),
                .st   (st_vec[gi]),
                .flip (flip_vec[gi])
            );
        end
    endgenerate

    // Walk downwards so the nearest pend after the last grant wins.
    always_comb begin
        grant_idx = '0;
        rr_idx    = 0;
        for (int k = NKEYS; k >= 1; k--) begin
            rr_idx = (int'(last_q) + k) % NKEYS;
            if (pend_q[rr_idx]) grant_idx = KW'(rr_idx);
        end
    end

    assign load = (!evt_valid_q || evt_ready) && (|pend_q);

    always_comb begin
        pend_d  = pend_q;
        ptype_d = ptype_q;
        cancel  = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (load && grant_idx == KW'(i)) pend_d[i] = 1'b0;
            if (flip_vec[i]) begin
                // An unserved event followed by its reverse is dropped as a pair.
                if (pend_q[i] && !(load && grant_idx == KW'(i))) begin
                    pend_d[i] = 1'b0;
                    cancel[i] = 1'b1;
                end else begin
                    pend_d[i]  = 1'b1;
                    ptype_d[i] = st_vec[i] ? EVT_RELEASE : EVT_PRESS;
                end
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_key_d   = evt_key_q;
        evt_rel_d   = evt_rel_q;
        last_d      = last_q;
        if (load) begin
            evt_valid_d = 1'b1;
            evt_key_d   = grant_idx;
            evt_rel_d   = ptype_q[grant_idx];
            last_d      = grant_idx;
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
        ovf_d = (ovf_q && !ovf_clr) || (|cancel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            pend_q      <= '0;
            ptype_q     <= '0;
            last_q      <= KW'(NKEYS - 1);
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_rel_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            presc_q     <= presc_q + PRESC_W'(1);
            pend_q      <= pend_d;
            ptype_q     <= ptype_d;
            last_q      <= last_d;
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_rel_q   <= evt_rel_d;
            ovf_q       <= ovf_d;
        end
    end

    assign key_state = st_vec;
    assign evt_valid = evt_valid_q;
    assign evt_key   = evt_key_q;
    assign evt_rel   = evt_rel_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: transaction-level reference model feeding an
// expected-event queue, with an independent monitor checking outputs.
module tb_key_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'b0;
    logic [3:0] key_state;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [1:0] evt_key;
    logic       evt_rel;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    key_event_ctrl #(.NKEYS(4), .PRESC_W(2), .DEB_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_state(key_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key  (evt_key),
        .evt_rel  (evt_rel),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: synchronised samples, run length of disagreeing ticks,
    // pending-event table, round-robin pick and one-entry output slot.
    int  m_s1[4], m_s2[4], m_st[4], m_run[4], m_pend[4], m_ptype[4], m_flip[4], m_pold[4];
    int  m_presc = 0, m_last = 3, m_slot = 0, m_ovf = 0, m_g = -1;
    bit  m_tick, m_load, m_cancel;
    int  exp_q[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_run[i] = 0;
                m_pend[i] = 0; m_ptype[i] = 0;
            end
            m_presc = 0; m_last = 3; m_slot = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            m_tick  = (m_presc == 3);
            m_presc = (m_presc + 1) % 4;
            for (int i = 0; i < 4; i++) begin
                m_flip[i] = 0;
                if (m_tick) begin
                    if (m_s2[i] != m_st[i]) begin
                        if (m_run[i] + 1 == 4) begin
                            m_flip[i] = 1;
                            m_run[i]  = 0;
                        end else begin
                            m_run[i]++;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(key_in[i]);
                m_pold[i] = m_pend[i];
            end
            m_g = -1;
            for (int k = 1; k <= 4; k++)
                if (m_g < 0 && m_pend[(m_last + k) % 4] != 0) m_g = (m_last + k) % 4;
            m_load = (m_g >= 0) && (m_slot == 0 || evt_ready);
            if (m_load) begin
                exp_q.push_back(m_g * 2 + m_ptype[m_g]);
                m_pend[m_g] = 0;
                m_last = m_g;
                m_slot = 1;
            end else if (m_slot != 0 && evt_ready) begin
                m_slot = 0;
            end
            m_cancel = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_flip[i] != 0) begin
                    if (m_pold[i] != 0 && !(m_load && m_g == i)) begin
                        m_pend[i] = 0;
                        m_cancel  = 1;
                    end else begin
                        m_pend[i]  = 1;
                        m_ptype[i] = m_st[i];
                    end
                    m_st[i] = 1 - m_st[i];
                end
            end
            m_ovf = ((m_ovf != 0 && !ovf_clr) || m_cancel) ? 1 : 0;
        end
    end

    // Monitor: per-cycle state checks, handshake scoreboard, hold stability.
    logic [3:0] e_ks;
    logic       p_valid = 1'b0, p_ready = 1'b0, p_rel = 1'b0;
    logic [1:0] p_key = 2'b0;
    int         e_evt;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < 4; i++) e_ks[i] = m_st[i][0];
            chk("key_state", 32'(key_state), 32'(e_ks));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("evt_valid", 32'(evt_valid), 32'(m_slot));
            if (p_valid && !p_ready) begin
                chk("hold_valid", 32'(evt_valid), 32'd1);
                chk("hold_key", 32'(evt_key), 32'(p_key));
                chk("hold_rel", 32'(evt_rel), 32'(p_rel));
            end
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_evt", 32'(evt_valid), 32'd0);
                end else begin
                    e_evt = exp_q.pop_front();
                    $display("evt key=%0d rel=%0d (expected key=%0d rel=%0d)",
                             evt_key, evt_rel, e_evt / 2, e_evt % 2);
                    chk("evt_key", 32'(evt_key), 32'(e_evt / 2));
                    chk("evt_rel", 32'(evt_rel), 32'(e_evt % 2));
                end
            end
            p_valid = evt_valid;
            p_ready = evt_ready;
            p_key   = evt_key;
            p_rel   = evt_rel;
        end else begin
            p_valid = 1'b0;
        end
    end

    initial begin
        int n;
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_keys", 32'(key_state), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(2);

        // Single press on key 2: state after 4 ticks, event one cycle later.
        key_in[2] = 1'b1;
        n = 0;
        while (!key_state[2] && n < 40) begin
            step(1);
            n++;
        end
        chk("s1_rise_in_time", 32'(n < 40), 32'd1);
        chk("s1_valid_lag", 32'(evt_valid), 32'd0);
        step(1);
        chk("s1_valid", 32'(evt_valid), 32'd1);
        chk("s1_key", 32'(evt_key), 32'd2);
        chk("s1_rel", 32'(evt_rel), 32'd0);
        step(1);
        chk("s1_single", 32'(evt_valid), 32'd0);
        step(10);

        // Bounces of three ticks never get through.
        repeat (3) begin
            key_in[1] = 1'b1;
            step(12);
            key_in[1] = 1'b0;
            step(8);
        end
        chk("s2_key1", 32'(key_state[1]), 32'd0);
        chk("s2_ovf", 32'(ovf), 32'd0);

        // Simultaneous acceptances, then round-robin from the last grant.
        key_in[0] = 1'b1; key_in[1] = 1'b1; key_in[3] = 1'b1;
        step(30);
        key_in[1] = 1'b0; key_in[0] = 1'b0;
        step(30);
        key_in[3] = 1'b0;
        step(30);

        // Key 2 holds the slot while key 0 press/release cancel out.
        evt_ready = 1'b0;
        key_in[2] = 1'b0;
        step(30);
        key_in[0] = 1'b1;
        step(30);
        key_in[0] = 1'b0;
        step(30);
        chk("s4_ovf_set", 32'(ovf), 32'd1);
        chk("s4_slot_key", 32'(evt_key), 32'd2);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("s4_ovf_clr", 32'(ovf), 32'd0);
        step(10);
        evt_ready = 1'b1;
        step(5);

        // Reset in the middle of a held event plus a pend.
        evt_ready = 1'b0;
        key_in[3] = 1'b1;
        step(30);
        key_in[1] = 1'b1;
        step(30);
        rst_n = 1'b0;
        #1;
        chk("s5_valid", 32'(evt_valid), 32'd0);
        chk("s5_keys", 32'(key_state), 32'd0);
        chk("s5_key", 32'(evt_key), 32'd0);
        chk("s5_rel", 32'(evt_rel), 32'd0);
        step(2);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        repeat (10) begin
            step(1);
            chk("s5_quiet", 32'(evt_valid), 32'd0);
        end
        step(30);
        key_in = 4'b0;
        step(30);

        // Randomised traffic.
        repeat (3000) begin
            if ($urandom_range(19, 0) == 0) key_in[$urandom_range(3, 0)] ^= 1'b1;
            evt_ready = ($urandom_range(3, 0) != 0);
            ovf_clr   = ($urandom_range(15, 0) == 0);
            step(1);
        end
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        step(40);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
